// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I field positions, fetch-unit state encoding and reset PC default.
// IFU_MISALIGN_TRAP_EN adds the FAULT state.
package rv32i_pkg;
   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 6;
   localparam int F3_LSB  = 12;
   localparam int F3_MSB  = 14;
   localparam int F7_LSB  = 25;
   localparam int F7_MSB  = 31;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
`ifdef IFU_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FAULT} ifu_state_t;
`else
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN} ifu_state_t;
`endif
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: registered {pc,instr} buffer with synchronous flush and occupancy count.
module ifu_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign do_pop  = pop && count != '0;
   assign do_push = push && (count != FULL || do_pop);
   assign rdata   = mem[rp];
   always_ff @(posedge clk)
      if (do_push && !flush) mem[wp] <= wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= wp + AW'(do_push);
         rp    <= rp + AW'(do_pop);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage -- PC, credit-limited imem reads, decode buffer, redirect/drain.
// IFU_MISALIGN_TRAP_EN: misaligned redirect targets trap into FAULT instead of being force-aligned.
module instr_fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PCSrc,
   input  logic        redir_valid,
   input  logic [31:0] PCTarget,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc4,
   output logic        fetch_fault
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
   ifu_state_t st, st_n;
   logic [31:0] fetch_pc, pc_n, rsp_pc, tgt;
   logic [CW-1:0] outst, out_n, disc, disc_n, cnt, cnt_n;
   logic redir, accept, hold, issue, push, pop;
   logic [63:0] head;
   assign redir  = redir_valid & PCSrc;
   assign accept = imem_req_valid & imem_req_ready;
   assign hold   = imem_req_valid & ~imem_req_ready;
   assign tgt    = PCTarget & ~32'd3;
   assign push   = imem_rsp_valid && st == ST_RUN && !redir;
   assign pop    = instr_valid & instr_ready;
   assign pc_n   = redir ? tgt : fetch_pc;
   assign out_n  = outst + CW'(accept) - CW'(imem_rsp_valid);
   assign cnt_n  = redir ? '0 : cnt + CW'(push) - CW'(pop);
   // next-cycle occupancy so a new request can never land in a full buffer
   assign issue  = !hold && st_n == ST_RUN && {1'b0, out_n} + {1'b0, cnt_n} < DEPTH_C;
`ifdef IFU_MISALIGN_TRAP_EN
   logic flt_pend, flt_pend_n;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) flt_pend <= 1'b0;
      else flt_pend <= flt_pend_n;
   assign fetch_fault = st == ST_FAULT;
`else
   assign fetch_fault = 1'b0;
`endif
   always_comb begin
      disc_n = disc - CW'(imem_rsp_valid && st == ST_DRAIN);
      if (redir && st != ST_DRAIN) disc_n = outst + CW'(imem_req_valid) - CW'(imem_rsp_valid);
`ifdef IFU_MISALIGN_TRAP_EN
      flt_pend_n = redir ? |PCTarget[1:0] : flt_pend;
      st_n = (!redir && st != ST_DRAIN) ? st : disc_n != '0 ? ST_DRAIN : flt_pend_n ? ST_FAULT : ST_RUN;
`else
      st_n = (!redir && st != ST_DRAIN) ? st : disc_n != '0 ? ST_DRAIN : ST_RUN;
`endif
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st             <= ST_RUN;
         fetch_pc       <= RESET_PC;
         rsp_pc         <= RESET_PC;
         imem_addr      <= RESET_PC;
         imem_req_valid <= 1'b0;
         outst          <= '0;
         disc           <= '0;
      end else begin
         st             <= st_n;
         outst          <= out_n;
         disc           <= disc_n;
         imem_req_valid <= hold | issue;
         fetch_pc       <= issue ? pc_n + 32'd4 : pc_n;
         if (issue) imem_addr <= pc_n;
         rsp_pc         <= redir ? tgt : push ? rsp_pc + 32'd4 : rsp_pc;
      end
   ifu_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redir),
      .push  (push),
      .pop   (pop),
      .wdata ({rsp_pc, imem_rsp_data}),
      .rdata (head),
      .count (cnt)
   );
   assign instr_valid = cnt != '0;
   assign instr       = head[31:0];
   assign instr_pc    = head[63:32];
   assign instr_pc4   = instr_pc + 32'd4;
   assign opcode      = instr[OPC_MSB:OPC_LSB];
   assign funct3      = instr[F3_MSB:F3_LSB];
   assign funct7      = instr[F7_MSB:F7_LSB];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, credit, redirect/drain, wrap and async reset.
module tb_instr_fetch_unit;
   logic clk = 0, rst_n = 0, PCSrc = 0, redir_valid = 0, imem_req_ready = 0;
   logic imem_rsp_valid = 0, instr_ready = 0, rsp_en = 0;
   logic [31:0] PCTarget = 0, imem_rsp_data = 0;
   logic imem_req_valid, instr_valid, fetch_fault;
   logic [31:0] imem_addr, instr, instr_pc, instr_pc4;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [31:0] pend[$], req_log[$];
   int tests = 0, fails = 0;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .redir_valid(redir_valid), .PCTarget(PCTarget),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .instr_pc(instr_pc), .instr_pc4(instr_pc4), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hF0E1_D2C3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock; the memory model answers in order, one word per cycle, the cycle after accept
   task automatic tick();
      logic acc;
      logic [31:0] a;
      acc = imem_req_valid && imem_req_ready;
      a = imem_addr;
      @(posedge clk);
      #1;
      if (imem_rsp_valid) void'(pend.pop_front());
      if (acc) begin
         pend.push_back(a);
         req_log.push_back(a);
      end
      imem_rsp_valid = rsp_en && pend.size() != 0;
      imem_rsp_data = pend.size() != 0 ? mem_word(pend[0]) : 32'h0;
   endtask

   task automatic redirect(input logic [31:0] t);
      redir_valid = 1;
      PCSrc = 1;
      PCTarget = t;
      tick();
      redir_valid = 0;
      PCSrc = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      #1;
      pend.delete();
      req_log.delete();
      imem_rsp_valid = 0;
      redir_valid = 0;
      PCSrc = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_instr_valid", 32'(instr_valid), 0);
      chk("rst_fetch_fault", 32'(fetch_fault), 0);
      // streaming fetch
      imem_req_ready = 1;
      rsp_en = 1;
      instr_ready = 1;
      rst_n = 1;
      tick();
      chk("t1_req_valid", 32'(imem_req_valid), 1);
      chk("t1_addr0", imem_addr, 32'h0);
      chk("t1_iv_c1", 32'(instr_valid), 0);
      tick();
      chk("t1_iv_c2", 32'(instr_valid), 0);
      chk("t1_addr4", imem_addr, 32'h4);
      tick();
      chk("t1_iv_c3", 32'(instr_valid), 1);
      chk("t1_instr", instr, 32'hF0E1_D2C3);
      chk("t1_opcode", 32'(opcode), 32'h43);
      chk("t1_funct3", 32'(funct3), 32'h5);
      chk("t1_funct7", 32'(funct7), 32'h78);
      chk("t1_pc", instr_pc, 32'h0);
      chk("t1_pc4", instr_pc4, 32'h4);
      chk("t1_req_idle", 32'(imem_req_valid), 0);
      tick();
      chk("t1_pc_next", instr_pc, 32'h4);
      chk("t1_addr8", imem_addr, 32'h8);
      repeat (4) tick();
      chk("t1_nreq", 32'(req_log.size() >= 4), 1);
      chk("t1_log2", req_log[2], 32'h8);
      chk("t1_log3", req_log[3], 32'hC);
      // back-pressure: credit limit
      do_reset();
      instr_ready = 0;
      repeat (6) tick();
      chk("t2_nreq", 32'(req_log.size()), 2);
      chk("t2_req_idle", 32'(imem_req_valid), 0);
      chk("t2_head_pc", instr_pc, 32'h0);
      instr_ready = 1;
      tick();
      instr_ready = 0;
      chk("t2_pop_pc", instr_pc, 32'h4);
      chk("t2_new_req", 32'(imem_req_valid), 1);
      chk("t2_new_addr", imem_addr, 32'h8);
      repeat (4) tick();
      chk("t2_nreq3", 32'(req_log.size()), 3);
      chk("t2_req_idle2", 32'(imem_req_valid), 0);
      // redirect with two outstanding
      do_reset();
      rsp_en = 0;
      instr_ready = 1;
      repeat (3) tick();
      chk("t3_req_idle", 32'(imem_req_valid), 0);
      rsp_en = 1;
      redirect(32'h100);
      chk("t3_iv_d0", 32'(instr_valid), 0);
      chk("t3_req_d0", 32'(imem_req_valid), 0);
      tick();
      chk("t3_iv_d1", 32'(instr_valid), 0);
      chk("t3_req_d1", 32'(imem_req_valid), 0);
      tick();
      chk("t3_iv_d2", 32'(instr_valid), 0);
      chk("t3_req_run", 32'(imem_req_valid), 1);
      chk("t3_addr", imem_addr, 32'h100);
      repeat (2) tick();
      chk("t3_iv", 32'(instr_valid), 1);
      chk("t3_pc", instr_pc, 32'h100);
      chk("t3_instr", instr, 32'hF0E1_D3C3);
      // push+pop hold, then redirect colliding with a response
      do_reset();
      instr_ready = 0;
      repeat (3) tick();
      chk("t4_pc0", instr_pc, 32'h0);
      instr_ready = 1;
      tick();
      chk("t4_pushpop_iv", 32'(instr_valid), 1);
      chk("t4_pushpop_pc", instr_pc, 32'h4);
      instr_ready = 0;
      tick();
      chk("t4_hold_pc", instr_pc, 32'h4);
      chk("t4_req_idle", 32'(imem_req_valid), 0);
      instr_ready = 1;
      redirect(32'h300);
      chk("t4_flush_iv", 32'(instr_valid), 0);
      chk("t4_addr", imem_addr, 32'h300);
      repeat (2) tick();
      chk("t4_iv", 32'(instr_valid), 1);
      chk("t4_pc", instr_pc, 32'h300);
      // misaligned redirect
      do_reset();
      redirect(32'h102);
`ifdef IFU_MISALIGN_TRAP_EN
      chk("t5_fault", 32'(fetch_fault), 1);
      chk("t5_req_idle", 32'(imem_req_valid), 0);
      repeat (3) tick();
      chk("t5_fault_hold", 32'(fetch_fault), 1);
      chk("t5_req_idle2", 32'(imem_req_valid), 0);
      chk("t5_iv", 32'(instr_valid), 0);
      redirect(32'h200);
      chk("t5_fault_clr", 32'(fetch_fault), 0);
      chk("t5_addr", imem_addr, 32'h200);
`else
      chk("t5_fault", 32'(fetch_fault), 0);
      chk("t5_addr", imem_addr, 32'h100);
      repeat (2) tick();
      chk("t5_pc", instr_pc, 32'h100);
`endif
      // PC wrap
      do_reset();
      instr_ready = 0;
      redirect(32'hFFFF_FFFC);
      chk("t7_addr", imem_addr, 32'hFFFF_FFFC);
      repeat (2) tick();
      chk("t7_pc", instr_pc, 32'hFFFF_FFFC);
      chk("t7_pc4", instr_pc4, 32'h0);
      chk("t7_nreq", 32'(req_log.size()), 2);
      chk("t7_wrap_addr", req_log[1], 32'h0);
      // async reset during DRAIN with a held request
      do_reset();
      instr_ready = 1;
      rsp_en = 0;
      repeat (2) tick();
      imem_req_ready = 0;
      redirect(32'h100);
      chk("t6_held", 32'(imem_req_valid), 1);
      chk("t6_held_addr", imem_addr, 32'h4);
      tick();
      chk("t6_held_addr2", imem_addr, 32'h4);
      rst_n = 0;
      #1;
      chk("t6_rst_req", 32'(imem_req_valid), 0);
      chk("t6_rst_iv", 32'(instr_valid), 0);
      chk("t6_rst_fault", 32'(fetch_fault), 0);
      do_reset();
      imem_req_ready = 1;
      rsp_en = 1;
      tick();
      chk("t6_refetch", 32'(imem_req_valid), 1);
      chk("t6_refetch_addr", imem_addr, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
